// File: rtl/fifo_pop_packer_if.sv
// Pop-side FIFO handshake plus packed output beat channel for fifo_pop_packer.
// The packer takes the slave modport; whoever feeds and drains it takes the master modport.
interface fifo_pop_packer_if #(
  parameter int W  = 32,
  parameter int K  = 4,
  parameter int LW = $clog2(K + 1)
);
  logic               in_empty;
  logic [W-1:0]       in_data;
  logic               in_pop;
  logic               flush;
  logic               out_valid_r;
  logic [K*W-1:0]     out_data_r;
  logic [LW-1:0]      out_len_r;
  logic               out_accept;
  logic               busy_r;

  modport slave (
    input  in_empty, in_data, flush, out_accept,
    output in_pop, out_valid_r, out_data_r, out_len_r, busy_r
  );

  modport master (
    output in_empty, in_data, flush, out_accept,
    input  in_pop, out_valid_r, out_data_r, out_len_r, busy_r
  );
endinterface

// File: rtl/fifo_pop_packer.sv
// Drains a FIFO pop port and packs K consecutive W-bit entries into one beat.
// A flush emits the partial beat with its lane count so trailing data is not stranded.
module fifo_pop_packer #(
  parameter int W = 32,
  parameter int K = 4,
  localparam int LW = $clog2(K + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_pop_packer_if.slave     bus
);
  localparam logic [LW-1:0] LAST = LW'(K - 1);

  logic [LW-1:0]           cnt_r;
  logic                    flush_pend_r;
  logic [K-2:0][W-1:0]     acc_r;
  logic                    out_valid_r;
  logic [K*W-1:0]          out_data_r;
  logic [LW-1:0]           out_len_r;
  logic                    busy_r;

  logic                    w_out_free;
  logic                    w_pop;
  logic                    w_beat_load;
  logic                    w_flush_load;
  logic [LW-1:0]           w_cnt_next;
  logic                    w_pend_next;

  // The last lane may only be popped when the output register can take the beat.
  assign w_out_free   = ~out_valid_r | bus.out_accept;
  assign w_pop        = rst & ~bus.in_empty & ~bus.flush & ~flush_pend_r
                      & ((cnt_r != LAST) | w_out_free);
  assign w_beat_load  = w_pop & (cnt_r == LAST);
  assign w_flush_load = flush_pend_r & (cnt_r != '0) & w_out_free;

  always_comb begin
    w_cnt_next  = cnt_r;
    w_pend_next = flush_pend_r;
    if (w_beat_load || w_flush_load) begin
      w_cnt_next = '0;
    end else if (w_pop) begin
      w_cnt_next = cnt_r + LW'(1);
    end
    // A flush arriving while one is pending is dropped, not queued.
    if (flush_pend_r) begin
      if ((cnt_r == '0) || w_out_free) begin
        w_pend_next = 1'b0;
      end
    end else if (bus.flush) begin
      w_pend_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || w_beat_load || w_flush_load) begin
      acc_r <= '0;
    end else begin
      for (int i = 0; i < K - 1; i++) begin
        if (w_pop && (cnt_r == LW'(i))) begin
          acc_r[i] <= bus.in_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r        <= '0;
      flush_pend_r <= 1'b0;
      busy_r       <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_len_r    <= '0;
    end else begin
      cnt_r        <= w_cnt_next;
      flush_pend_r <= w_pend_next;
      busy_r       <= (w_cnt_next != '0) | w_pend_next;
      if (w_beat_load) begin
        out_data_r  <= {bus.in_data, acc_r};
        out_len_r   <= LW'(K);
        out_valid_r <= 1'b1;
      end else if (w_flush_load) begin
        out_data_r  <= {{W{1'b0}}, acc_r};
        out_len_r   <= cnt_r;
        out_valid_r <= 1'b1;
      end else if (bus.out_accept) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.in_pop      = w_pop;
  assign bus.out_valid_r = out_valid_r;
  assign bus.out_data_r  = out_data_r;
  assign bus.out_len_r   = out_len_r;
  assign bus.busy_r      = busy_r;

  always @(posedge clk) begin
    if (rst) begin
      assert (!(w_pop && bus.in_empty));
      assert (cnt_r <= LAST);
      assert (!(out_valid_r && (out_len_r == '0)));
    end
  end

  assert property (@(posedge clk) disable iff (!rst)
    (out_valid_r && !bus.out_accept) |=> ($stable(out_data_r) && $stable(out_len_r)));

endmodule

// File: tb/tb_fifo_pop_packer.sv
// Directed bench for fifo_pop_packer (W=32, K=4) with a small array-backed FIFO model.
module tb_fifo_pop_packer;
  logic clk;
  logic rst;

  fifo_pop_packer_if #(.W(32), .K(4)) bus ();

  fifo_pop_packer #(.W(32), .K(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  assign bus.in_empty = (rd_ptr == wr_ptr);
  assign bus.in_data  = mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (bus.in_pop) rd_ptr <= rd_ptr + 1;
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [127:0] data, input logic [2:0] len);
    check({tag, "_valid"}, 128'(bus.out_valid_r), 128'(1));
    check({tag, "_data"}, bus.out_data_r, data);
    check({tag, "_len"}, 128'(bus.out_len_r), 128'(len));
    $display("beat %s data=%h len=%0d", tag, bus.out_data_r, bus.out_len_r);
  endtask

  task automatic push(input logic [31:0] v);
    mem[wr_ptr[5:0]] = v;
    wr_ptr++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst            = 1'b0;
    bus.flush      = 1'b0;
    bus.out_accept = 1'b0;

    // 1: reset hold and release with an empty FIFO
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 2) rst = 1'b1;
      #1;
      check("t1_pop", 128'(bus.in_pop), 128'(0));
      check("t1_valid", 128'(bus.out_valid_r), 128'(0));
      check("t1_len", 128'(bus.out_len_r), 128'(0));
      check("t1_busy", 128'(bus.busy_r), 128'(0));
    end

    // 2: two back-to-back beats, one pop every cycle
    bus.out_accept = 1'b1;
    for (int i = 0; i < 8; i++) push(32'h10 + 32'(i));
    #1;
    for (int i = 0; i < 8; i++) begin
      check("t2_pop", 128'(bus.in_pop), 128'(1));
      step();
      if (i == 3) check_beat("t2_b1", 128'h00000013_00000012_00000011_00000010, 3'd4);
      if (i == 4) check("t2_retire", 128'(bus.out_valid_r), 128'(0));
      if (i == 7) check_beat("t2_b2", 128'h00000017_00000016_00000015_00000014, 3'd4);
    end
    check("t2_pop_empty", 128'(bus.in_pop), 128'(0));
    step();
    check("t2_valid_off", 128'(bus.out_valid_r), 128'(0));
    check("t2_busy", 128'(bus.busy_r), 128'(0));

    // 3: stalled consumer holds beat 1 and blocks the last pop of beat 2
    bus.out_accept = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h20 + 32'(i));
    for (int i = 0; i < 4; i++) step();
    for (int j = 0; j < 10; j++) begin
      check_beat("t3_hold", 128'h00000023_00000022_00000021_00000020, 3'd4);
      step();
    end
    check("t3_pop_blocked", 128'(bus.in_pop), 128'(0));
    check("t3_busy", 128'(bus.busy_r), 128'(1));
    bus.out_accept = 1'b1;
    #1;
    check("t3_pop_release", 128'(bus.in_pop), 128'(1));
    step();
    check_beat("t3_b2", 128'h00000027_00000026_00000025_00000024, 3'd4);
    step();
    check("t3_valid_off", 128'(bus.out_valid_r), 128'(0));

    // 4: partial beat flushed
    push(32'hA);
    push(32'hB);
    step();
    step();
    check("t4_pop_empty", 128'(bus.in_pop), 128'(0));
    bus.flush = 1'b1;
    #1;
    check("t4_pop_flush", 128'(bus.in_pop), 128'(0));
    step();
    bus.flush = 1'b0;
    check("t4_wait_valid", 128'(bus.out_valid_r), 128'(0));
    check("t4_wait_busy", 128'(bus.busy_r), 128'(1));
    step();
    check_beat("t4_partial", 128'h00000000_00000000_0000000B_0000000A, 3'd2);
    check("t4_busy_after", 128'(bus.busy_r), 128'(0));
    step();
    check("t4_valid_off", 128'(bus.out_valid_r), 128'(0));

    // 5: flush with nothing held, second flush while pending is dropped
    bus.flush = 1'b1;
    step();
    check("t5_busy_pend", 128'(bus.busy_r), 128'(1));
    step();
    bus.flush = 1'b0;
    check("t5_busy_clear", 128'(bus.busy_r), 128'(0));
    check("t5_no_beat", 128'(bus.out_valid_r), 128'(0));
    step();
    check("t5_ignored", 128'(bus.busy_r), 128'(0));
    check("t5_no_beat2", 128'(bus.out_valid_r), 128'(0));

    // 6: reset with a stalled beat and three held lanes, then refill
    bus.out_accept = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h30 + 32'(i));
    for (int i = 0; i < 7; i++) step();
    check_beat("t6_stalled", 128'h00000033_00000032_00000031_00000030, 3'd4);
    check("t6_pop_blocked", 128'(bus.in_pop), 128'(0));
    check("t6_busy", 128'(bus.busy_r), 128'(1));
    rst = 1'b0;
    #1;
    check("t6_pop_in_reset", 128'(bus.in_pop), 128'(0));
    step();
    check("t6_valid", 128'(bus.out_valid_r), 128'(0));
    check("t6_data", bus.out_data_r, 128'h0);
    check("t6_len", 128'(bus.out_len_r), 128'(0));
    check("t6_busy_clr", 128'(bus.busy_r), 128'(0));
    rst = 1'b1;
    bus.out_accept = 1'b1;
    push(32'h40);
    push(32'h41);
    push(32'h42);
    for (int i = 0; i < 4; i++) step();
    check_beat("t6_refill", 128'h00000042_00000041_00000040_00000037, 3'd4);
    step();
    check("t6_valid_off", 128'(bus.out_valid_r), 128'(0));
    check("t6_busy_end", 128'(bus.busy_r), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
